// File: rtl/serial_compare_arbiter.sv
// Round-robin front end that feeds one MSB-first serial magnitude comparator from two
// parallel requesters and returns a one-hot, ID-tagged result over valid/ready.
module serial_compare_arbiter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [W-1:0] req0_a,
    input  logic [W-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [W-1:0] req1_a,
    input  logic [W-1:0] req1_b,
    output logic         res_valid,
    input  logic         res_ready,
    output logic         res_id,
    output logic         res_less,
    output logic         res_eq,
    output logic         res_greater,
    output logic         busy
);

    localparam int CW = $clog2(W);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t        state;
    logic          last_grant;
    logic [W-1:0]  sa;
    logic [W-1:0]  sb;
    logic [CW-1:0] cnt;
    logic          eq;
    logic          gt;

    logic grant0;
    logic grant1;
    logic eq_next;
    logic gt_next;

    // Requester 0 wins a tie unless it was the last one served.
    assign grant0     = req0_valid & (~req1_valid | last_grant);
    assign grant1     = req1_valid & ~grant0;
    assign req0_ready = (state == IDLE) & grant0;
    assign req1_ready = (state == IDLE) & grant1;
    assign busy       = (state != IDLE);

    // The first differing bit from the MSB decides; later bits cannot change the verdict.
    assign eq_next = eq & (sa[W-1] == sb[W-1]);
    assign gt_next = gt | (eq & sa[W-1] & ~sb[W-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            sa          <= '0;
            sb          <= '0;
            cnt         <= '0;
            eq          <= 1'b0;
            gt          <= 1'b0;
            res_valid   <= 1'b0;
            res_id      <= 1'b0;
            res_less    <= 1'b0;
            res_eq      <= 1'b0;
            res_greater <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant0 | grant1) begin
                        sa         <= grant0 ? req0_a : req1_a;
                        sb         <= grant0 ? req0_b : req1_b;
                        res_id     <= grant1;
                        last_grant <= grant1;
                        eq         <= 1'b1;
                        gt         <= 1'b0;
                        cnt        <= CW'(W - 1);
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    eq <= eq_next;
                    gt <= gt_next;
                    sa <= {sa[W-2:0], 1'b0};
                    sb <= {sb[W-2:0], 1'b0};
                    if (cnt == '0) begin
                        res_eq      <= eq_next;
                        res_greater <= gt_next;
                        res_less    <= ~eq_next & ~gt_next;
                        res_valid   <= 1'b1;
                        state       <= DONE;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_compare_arbiter.sv
// Directed bench for serial_compare_arbiter: expected results are queued at accept and
// compared when the result handshake completes.
module tb_serial_compare_arbiter;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         res_valid;
    logic         res_ready;
    logic         res_id;
    logic         res_less;
    logic         res_eq;
    logic         res_greater;
    logic         busy;

    typedef struct {
        logic id;
        logic less;
        logic eq;
        logic gt;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   vectors = 0;
    int   errors  = 0;

    serial_compare_arbiter #(.W(W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_id     (res_id),
        .res_less   (res_less),
        .res_eq     (res_eq),
        .res_greater(res_greater),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pushExpected(input logic id, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        e.id   = id;
        e.less = (a < b);
        e.eq   = (a == b);
        e.gt   = (a > b);
        sb.push_back(e);
    endtask

    // Drive one request at a negedge and return at the negedge after its accept edge.
    task automatic applyStimulus(input logic id, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        if (id == 1'b0) begin
            req0_a = a; req0_b = b; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_valid = 1'b1;
        end
        #1;
        n = 0;
        while (((id == 1'b0) ? req0_ready : req1_ready) !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkVal("accept_ready", {31'b0, (id == 1'b0) ? req0_ready : req1_ready}, 32'd1);
        pushExpected(id, a, b);
        @(posedge clk);
        @(negedge clk);
        if (id == 1'b0) req0_valid = 1'b0;
        else            req1_valid = 1'b0;
    endtask

    task automatic waitResult();
        int n;
        n = 0;
        while (res_valid !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkVal("res_latency", n, W);
    endtask

    task automatic checkOutput();
        if (sb.size() == 0) begin
            checkVal("scoreboard_empty", 32'd0, 32'd1);
            return;
        end
        cur = sb.pop_front();
        checkVal("res_valid", {31'b0, res_valid}, 32'd1);
        checkVal("res_id", {31'b0, res_id}, {31'b0, cur.id});
        checkVal("res_flags", {29'b0, res_less, res_eq, res_greater},
                 {29'b0, cur.less, cur.eq, cur.gt});
    endtask

    task automatic finishResult();
        @(negedge clk);
        checkVal("post_valid", {31'b0, res_valid}, 32'd0);
        checkVal("post_busy", {31'b0, busy}, 32'd0);
    endtask

    logic [W-1:0] r0a [3];
    logic [W-1:0] r0b [3];
    logic [W-1:0] r1a [3];
    logic [W-1:0] r1b [3];

    initial begin
        int  n;
        int  idx;
        logic g;
        logic seen_valid;

        r0a = '{8'h11, 8'h99, 8'h00};
        r0b = '{8'h22, 8'h99, 8'h00};
        r1a = '{8'h80, 8'h02, 8'h00};
        r1b = '{8'h7F, 8'h01, 8'h00};

        rst_n      = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_a     = '0;
        req0_b     = '0;
        req1_a     = '0;
        req1_b     = '0;
        res_ready  = 1'b1;

        @(negedge clk);
        @(negedge clk);
        checkVal("rst_res_valid", {31'b0, res_valid}, 32'd0);
        checkVal("rst_res_id", {31'b0, res_id}, 32'd0);
        checkVal("rst_flags", {29'b0, res_less, res_eq, res_greater}, 32'd0);
        checkVal("rst_busy", {31'b0, busy}, 32'd0);
        checkVal("rst_ready", {30'b0, req0_ready, req1_ready}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] basic compares");
        applyStimulus(1'b0, 8'hA5, 8'hA4);
        waitResult(); checkOutput(); finishResult();
        applyStimulus(1'b1, 8'h7F, 8'h80);
        waitResult(); checkOutput(); finishResult();
        applyStimulus(1'b0, 8'h3C, 8'h3C);
        waitResult(); checkOutput(); finishResult();

        $display("[TB] operands changed after accept");
        applyStimulus(1'b0, 8'h10, 8'h20);
        req0_a = 8'hFF;
        req0_b = 8'h00;
        waitResult(); checkOutput(); finishResult();

        $display("[TB] result held under backpressure");
        res_ready = 1'b0;
        applyStimulus(1'b1, 8'h55, 8'h44);
        waitResult(); checkOutput();
        req0_a     = 8'h01;
        req0_b     = 8'hFE;
        req0_valid = 1'b1;
        for (int h = 0; h < 5; h++) begin
            @(negedge clk);
            checkVal("hold_valid", {31'b0, res_valid}, 32'd1);
            checkVal("hold_flags", {28'b0, res_id, res_less, res_eq, res_greater},
                     {28'b0, cur.id, cur.less, cur.eq, cur.gt});
            checkVal("hold_busy", {31'b0, busy}, 32'd1);
            checkVal("hold_no_ready", {30'b0, req0_ready, req1_ready}, 32'd0);
        end
        res_ready = 1'b1;
        @(negedge clk);
        checkVal("release_valid", {31'b0, res_valid}, 32'd0);
        checkVal("release_busy", {31'b0, busy}, 32'd0);
        checkVal("release_ready", {31'b0, req0_ready}, 32'd1);
        pushExpected(1'b0, 8'h01, 8'hFE);
        @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b0;
        waitResult(); checkOutput(); finishResult();

        $display("[TB] reset during shift");
        applyStimulus(1'b0, 8'hC3, 8'h3C);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkVal("midrst_busy", {31'b0, busy}, 32'd0);
        checkVal("midrst_valid", {31'b0, res_valid}, 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        seen_valid = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (res_valid === 1'b1) seen_valid = 1'b1;
        end
        checkVal("midrst_no_result", {31'b0, seen_valid}, 32'd0);

        $display("[TB] contention");
        req0_a = r0a[0]; req0_b = r0b[0];
        req1_a = r1a[0]; req1_b = r1b[0];
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            g   = k[0];
            idx = k / 2;
            n   = 0;
            while (req0_ready !== 1'b1 && req1_ready !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            checkVal("grant_order", {30'b0, req0_ready, req1_ready}, (g == 1'b0) ? 32'd2 : 32'd1);
            if (g == 1'b0) pushExpected(1'b0, r0a[idx], r0b[idx]);
            else           pushExpected(1'b1, r1a[idx], r1b[idx]);
            @(posedge clk);
            @(negedge clk);
            if (g == 1'b0) begin
                req0_a = r0a[idx+1]; req0_b = r0b[idx+1];
            end else begin
                req1_a = r1a[idx+1]; req1_b = r1b[idx+1];
            end
            waitResult(); checkOutput(); finishResult();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/serial_compare_arbiter.md
# serial_compare_arbiter

Shares one MSB-first serial magnitude comparator between two parallel requesters. The block arbitrates round-robin, accepts one W-bit operand pair, and shifts it MSB-first through the serial compare datapath over W cycles. It then returns a one-hot less/equal/greater result, tagged with the requester ID, over a valid/ready handshake. It sits between producer logic that holds operands in parallel and the bit-serial comparator datapath.

## Interface
- W, default 8: operand width in bits; legal range W >= 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operand pair.
- req0_ready  out  1  requester 0 accepted this cycle.
- req0_a, req0_b  in  W  requester 0 operands.
- req1_valid, req1_ready, req1_a, req1_b: same as requester 0, for requester 1.
- res_valid  out  1  result available.
- res_ready  in  1  consumer takes the result.
- res_id  out  1  requester that issued the compare.
- res_less, res_eq, res_greater  out  1 each  one-hot result of comparing a against b (unsigned).
- busy  out  1  high in SHIFT or DONE.

## Operation
- Reset: one clock, asynchronous active-low (rst_n). Polarity and synchronicity are fixed.
- FSM states: IDLE, SHIFT, DONE. Reset state is IDLE.
- Grant in IDLE:
  - grant0 = req0_valid & (~req1_valid | last_grant == 1).
  - grant1 = req1_valid & ~grant0.
  - reqN_ready = (state == IDLE) & grantN. It is combinational, and ready is never asserted without valid.
- Accept edge (valid & ready):
  - Latch a and b into W-bit shift registers sa, sb.
  - Set res_id and last_grant to the granted index.
  - Set the compare state to eq = 1, gt = 0.
  - Set the bit counter to W-1 and go to SHIFT.
- SHIFT, each cycle:
  - Serial bits are sa[W-1] and sb[W-1].
  - eq_next = eq & (sa[W-1] == sb[W-1]).
  - gt_next = gt | (eq & sa[W-1] & ~sb[W-1]).
  - Shift sa and sb left by one.
  - If the counter is 0, go to DONE; otherwise decrement the counter.
  - Exactly W bits are consumed. There is no early termination.
- Entry to DONE: register res_eq = eq_next, res_greater = gt_next, res_less = ~eq_next & ~gt_next. res_valid = 1.
- DONE:
  - Hold all res_* outputs stable while res_ready = 0.
  - On res_valid & res_ready, clear res_valid and go to IDLE.
  - No request is accepted in DONE or SHIFT.
- The counter is $clog2(W) bits wide and never wraps: it reaches 0 then the FSM exits.

## Timing
- Reset values:
  - state = IDLE, last_grant = 1 (requester 0 wins the first contention).
  - res_valid = 0, res_id = 0, res_less = 0, res_eq = 0, res_greater = 0.
  - sa = sb = 0, busy = 0.
  - reqN_ready follows the grant equations (IDLE).
- Latency: accept on edge E0, then W SHIFT edges E1..EW. res_valid is high in the cycle after EW, i.e. W+1 cycles after the accept cycle.
- Throughput: minimum W+2 cycles per compare (accept, W shifts, 1 DONE cycle with immediate res_ready).
- Simultaneous valid on both requesters: only the granted one sees ready. The other keeps valid asserted and is granted at the next IDLE.
- A requester dropping valid before grant is legal. Operands are sampled only on the accept edge, so later changes to req*_a/b do not affect the result.
- Reset mid-operation (SHIFT or DONE):
  - The operation is abandoned immediately and no result is delivered.
  - All outputs and last_grant return to their reset values.
- res_less, res_eq and res_greater are exactly one-hot whenever res_valid = 1.

## Test plan
- W=8, req0 a=8'hA5, b=8'hA4, res_ready=1 -> res_valid 9 cycles after accept, res_greater=1, res_id=0, then IDLE.
- req1 a=8'h7F, b=8'h80 -> res_less=1 (the MSB decides despite lower bits a>b). a=b=8'h3C -> res_eq=1.
- Both valid continuously from reset, with distinct operands -> grants alternate 0,1,0,1. res_id matches each accepted pair. Neither requester is starved.
- res_ready held 0 for 5 cycles in DONE -> res_* stable, busy=1, no req ready. res_ready=1 -> IDLE next cycle, new accept possible the cycle after.
- rst_n asserted at the 4th SHIFT cycle -> res_valid stays 0, busy=0 immediately. After release, a new contention grants requester 0.
- Operands changed on req0_a/b during SHIFT -> result reflects the values latched at the accept edge.
